// File: rtl/fpu_writeback_arbiter.sv
// FP register-file write front end: per-unit result buffers, round-robin write port, pending-write scoreboard.
// Define FWB_FFLAGS_EN to add per-result IEEE exception flags and a sticky fflags_o accumulator.
module fpu_writeback_arbiter #(
   parameter int unsigned N_SRC  = 4,
   parameter int unsigned FREG_N = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                flush_i,
   input  logic [N_SRC-1:0]    src_valid_i,
   output logic [N_SRC-1:0]    src_ready_o,
   input  logic [N_SRC*5-1:0]  src_faddr_i,
   input  logic [N_SRC*32-1:0] src_fdata_i,
`ifdef FWB_FFLAGS_EN
   input  logic [N_SRC*5-1:0]  src_fflags_i,
   input  logic                fflags_clr_i,
   output logic [4:0]          fflags_o,
`endif
   input  logic                issue_set_i,
   input  logic [4:0]          issue_faddr_i,
   output logic [FREG_N-1:0]   busy_o,
   output logic                we_o,
   output logic [4:0]          w_faddr_o,
   output logic [31:0]         wr_fdata_o
);

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;
   localparam int unsigned PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   logic [N_SRC-1:0]  hold_valid_q, hold_valid_d;
   logic [AW-1:0]     hold_addr_q [N_SRC];
   logic [AW-1:0]     hold_addr_d [N_SRC];
   logic [DW-1:0]     hold_data_q [N_SRC];
   logic [DW-1:0]     hold_data_d [N_SRC];
   logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
   logic              we_q, we_d;
   logic [AW-1:0]     waddr_q, waddr_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic [FREG_N-1:0] busy_q, busy_d;

   logic [N_SRC-1:0]  grant;
   logic              any_gnt;
   logic [PW-1:0]     gnt_idx;
   int unsigned       idx;

`ifdef FWB_FFLAGS_EN
   logic [4:0] hold_flags_q [N_SRC];
   logic [4:0] hold_flags_d [N_SRC];
   logic [4:0] wflags_q, wflags_d;
   logic [4:0] fflags_q, fflags_d;
`endif

   // Round-robin search starting at rr_ptr, wrapping modulo N_SRC.
   always_comb begin
      grant   = '0;
      any_gnt = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         idx = 32'(rr_ptr_q) + i;
         if (idx >= N_SRC) idx = idx - N_SRC;
         if (!any_gnt && hold_valid_q[PW'(idx)]) begin
            any_gnt             = 1'b1;
            gnt_idx             = PW'(idx);
            grant[PW'(idx)]     = 1'b1;
         end
      end
   end

   // A granted slot can be refilled in the same cycle.
   assign src_ready_o = (rst_i || flush_i) ? '0 : (~hold_valid_q | grant);

   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_addr_d  = hold_addr_q;
      hold_data_d  = hold_data_q;
      rr_ptr_d     = rr_ptr_q;
      we_d         = 1'b0;
      waddr_d      = waddr_q;
      wdata_d      = wdata_q;
      busy_d       = busy_q;
`ifdef FWB_FFLAGS_EN
      hold_flags_d = hold_flags_q;
      wflags_d     = wflags_q;
      fflags_d     = (fflags_clr_i ? 5'b0 : fflags_q) | (we_q ? wflags_q : 5'b0);
`endif

      if (any_gnt) begin
         we_d                  = 1'b1;
         waddr_d               = hold_addr_q[gnt_idx];
         wdata_d               = hold_data_q[gnt_idx];
         hold_valid_d[gnt_idx] = 1'b0;
         rr_ptr_d              = (gnt_idx == PW'(N_SRC - 1)) ? '0 : gnt_idx + PW'(1);
`ifdef FWB_FFLAGS_EN
         wflags_d              = hold_flags_q[gnt_idx];
`endif
      end

      for (int unsigned k = 0; k < N_SRC; k++) begin
         if (src_valid_i[PW'(k)] && src_ready_o[PW'(k)]) begin
            hold_valid_d[PW'(k)] = 1'b1;
            hold_addr_d[PW'(k)]  = src_faddr_i[k*AW +: AW];
            hold_data_d[PW'(k)]  = src_fdata_i[k*DW +: DW];
`ifdef FWB_FFLAGS_EN
            hold_flags_d[PW'(k)] = src_fflags_i[k*5 +: 5];
`endif
         end
      end

      // Set wins over a same-cycle clear of the same register.
      if (we_q) busy_d[waddr_q] = 1'b0;
      if (issue_set_i) busy_d[issue_faddr_i] = 1'b1;

      if (flush_i) begin
         hold_valid_d = '0;
         busy_d       = '0;
         we_d         = 1'b0;
         rr_ptr_d     = rr_ptr_q;
         waddr_d      = waddr_q;
         wdata_d      = wdata_q;
`ifdef FWB_FFLAGS_EN
         wflags_d     = wflags_q;
`endif
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hold_valid_q <= '0;
         hold_addr_q  <= '{default: '0};
         hold_data_q  <= '{default: '0};
         rr_ptr_q     <= '0;
         we_q         <= 1'b0;
         waddr_q      <= '0;
         wdata_q      <= '0;
         busy_q       <= '0;
`ifdef FWB_FFLAGS_EN
         hold_flags_q <= '{default: '0};
         wflags_q     <= '0;
         fflags_q     <= '0;
`endif
      end else begin
         hold_valid_q <= hold_valid_d;
         hold_addr_q  <= hold_addr_d;
         hold_data_q  <= hold_data_d;
         rr_ptr_q     <= rr_ptr_d;
         we_q         <= we_d;
         waddr_q      <= waddr_d;
         wdata_q      <= wdata_d;
         busy_q       <= busy_d;
`ifdef FWB_FFLAGS_EN
         hold_flags_q <= hold_flags_d;
         wflags_q     <= wflags_d;
         fflags_q     <= fflags_d;
`endif
      end
   end

   assign we_o       = we_q;
   assign w_faddr_o  = waddr_q;
   assign wr_fdata_o = wdata_q;
   assign busy_o     = busy_q;
`ifdef FWB_FFLAGS_EN
   assign fflags_o   = fflags_q;
`endif

endmodule

// File: tb/tb_fpu_writeback_arbiter.sv
// Directed bench for fpu_writeback_arbiter: expected writes queued at handshake, checked as we_o fires.
module tb_fpu_writeback_arbiter;

   logic         clk = 1'b0;
   logic         rst_i;
   logic         flush_i;
   logic [3:0]   src_valid_i;
   logic [3:0]   src_ready_o;
   logic [19:0]  src_faddr_i;
   logic [127:0] src_fdata_i;
   logic         issue_set_i;
   logic [4:0]   issue_faddr_i;
   logic [31:0]  busy_o;
   logic         we_o;
   logic [4:0]   w_faddr_o;
   logic [31:0]  wr_fdata_o;
`ifdef FWB_FFLAGS_EN
   logic [19:0]  src_fflags_i;
   logic         fflags_clr_i;
   logic [4:0]   fflags_o;
`endif

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t exp_q[$];
   int  n_cmp = 0;
   int  n_err = 0;
   int  seq[4];

   always #5 clk = ~clk;

   fpu_writeback_arbiter #(.N_SRC(4), .FREG_N(32)) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .flush_i       (flush_i),
      .src_valid_i   (src_valid_i),
      .src_ready_o   (src_ready_o),
      .src_faddr_i   (src_faddr_i),
      .src_fdata_i   (src_fdata_i),
`ifdef FWB_FFLAGS_EN
      .src_fflags_i  (src_fflags_i),
      .fflags_clr_i  (fflags_clr_i),
      .fflags_o      (fflags_o),
`endif
      .issue_set_i   (issue_set_i),
      .issue_faddr_i (issue_faddr_i),
      .busy_o        (busy_o),
      .we_o          (we_o),
      .w_faddr_o     (w_faddr_o),
      .wr_fdata_o    (wr_fdata_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Every committed write must match the oldest queued expectation.
   task automatic mon();
      wr_t e;
      if (we_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("we_without_pending", 64'(we_o), 64'(0));
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 64'(w_faddr_o), 64'(e.a));
            chk("wr_data", 64'(wr_fdata_o), 64'(e.d));
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      mon();
   endtask

   task automatic set_src(input int k, input logic v, input logic [4:0] a, input logic [31:0] d);
      src_valid_i[k]        = v;
      src_faddr_i[k*5 +: 5]   = a;
      src_fdata_i[k*32 +: 32] = d;
   endtask

   task automatic push(input logic [4:0] a, input logic [31:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
   endtask

   initial begin
      logic [3:0]  er;
      logic [31:0] dv;

      rst_i         = 1'b1;
      flush_i       = 1'b0;
      src_valid_i   = '0;
      src_faddr_i   = '0;
      src_fdata_i   = '0;
      issue_set_i   = 1'b0;
      issue_faddr_i = '0;
`ifdef FWB_FFLAGS_EN
      src_fflags_i  = '0;
      fflags_clr_i  = 1'b0;
`endif
      tick();
      tick();
      chk("rst_we", 64'(we_o), 64'(0));
      chk("rst_busy", 64'(busy_o), 64'(0));
      chk("rst_addr", 64'(w_faddr_o), 64'(0));
      chk("rst_data", 64'(wr_fdata_o), 64'(0));
      chk("rst_ready", 64'(src_ready_o), 64'(0));
`ifdef FWB_FFLAGS_EN
      chk("rst_fflags", 64'(fflags_o), 64'(0));
`endif
      rst_i = 1'b0;
      #1;
      chk("ready_after_rst", 64'(src_ready_o), 64'hF);

      // Single result, two-cycle latency, scoreboard clear.
      issue_set_i = 1'b1; issue_faddr_i = 5'd5;
      tick();
      issue_set_i = 1'b0;
      chk("single_busy_set", 64'(busy_o), 64'h20);
      set_src(0, 1'b1, 5'd5, 32'h3F80_0000);
      push(5'd5, 32'h3F80_0000);
      tick();
      set_src(0, 1'b0, 5'd0, 32'h0);
      chk("single_lat1_we", 64'(we_o), 64'(0));
      tick();
      chk("single_lat2_we", 64'(we_o), 64'(1));
      chk("single_busy_pending", 64'(busy_o), 64'h20);
      tick();
      chk("single_busy_clr", 64'(busy_o), 64'(0));
      chk("single_we_drop", 64'(we_o), 64'(0));

      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;

      // Full contention: sources commit 0,1,2,3,0,... back to back.
      for (int k = 0; k < 4; k++) seq[k] = 0;
      for (int c = 0; c < 16; c++) begin
         er = (c == 0) ? 4'hF : 4'(1 << ((c - 1) % 4));
         for (int k = 0; k < 4; k++) set_src(k, 1'b1, 5'(k + 1), {8'(k), 24'(seq[k])});
         #1;
         chk("cont_ready", 64'(src_ready_o), 64'(er));
         for (int k = 0; k < 4; k++) if (er[k]) push(5'(k + 1), {8'(k), 24'(seq[k])});
         tick();
         for (int k = 0; k < 4; k++) if (er[k]) seq[k]++;
         if (c >= 1) chk("cont_we", 64'(we_o), 64'(1));
      end
      src_valid_i = '0;
      repeat (6) tick();
      chk("cont_drained", 64'(exp_q.size()), 64'(0));

      // Set and clear of register 9 in the same cycle.
      set_src(2, 1'b1, 5'd9, 32'hC049_0FDB);
      push(5'd9, 32'hC049_0FDB);
      tick();
      src_valid_i = '0;
      tick();
      issue_set_i = 1'b1; issue_faddr_i = 5'd9;
      tick();
      issue_set_i = 1'b0;
      chk("collision_busy", 64'(busy_o), 64'h200);

      // Flush with three buffered entries.
      issue_set_i = 1'b1; issue_faddr_i = 5'd10;
      tick();
      issue_faddr_i = 5'd11;
      tick();
      issue_set_i = 1'b0;
      chk("flush_busy_pre", 64'(busy_o), 64'hE00);
      set_src(0, 1'b1, 5'd20, 32'h1111_0000);
      set_src(1, 1'b1, 5'd21, 32'h2222_0000);
      set_src(2, 1'b1, 5'd22, 32'h3333_0000);
      tick();
      src_valid_i = '0;
      set_src(3, 1'b1, 5'd23, 32'h4444_0000);
      flush_i = 1'b1;
      issue_set_i = 1'b1; issue_faddr_i = 5'd12;
      #1;
      chk("flush_ready_during", 64'(src_ready_o), 64'(0));
      tick();
      flush_i = 1'b0;
      issue_set_i = 1'b0;
      src_valid_i = '0;
      #1;
      chk("flush_ready_after", 64'(src_ready_o), 64'hF);
      chk("flush_busy", 64'(busy_o), 64'(0));
      chk("flush_we", 64'(we_o), 64'(0));
      repeat (5) tick();
      chk("flush_quiet_we", 64'(we_o), 64'(0));

      // Synchronous reset mid-stream, then round-robin restarts at source 0.
      issue_set_i = 1'b1; issue_faddr_i = 5'd3;
      tick();
      issue_set_i = 1'b0;
      set_src(1, 1'b1, 5'd14, 32'h5555_0000);
      set_src(2, 1'b1, 5'd15, 32'h6666_0000);
      tick();
      src_valid_i = '0;
      rst_i = 1'b1;
      #1;
      chk("rstmid_ready", 64'(src_ready_o), 64'(0));
      tick();
      chk("rstmid_we", 64'(we_o), 64'(0));
      chk("rstmid_addr", 64'(w_faddr_o), 64'(0));
      chk("rstmid_data", 64'(wr_fdata_o), 64'(0));
      chk("rstmid_busy", 64'(busy_o), 64'(0));
      rst_i = 1'b0;
      set_src(0, 1'b1, 5'd6, 32'h4049_0000);
      set_src(3, 1'b1, 5'd7, 32'h40A0_0000);
      push(5'd6, 32'h4049_0000);
      push(5'd7, 32'h40A0_0000);
      tick();
      src_valid_i = '0;
      chk("rstmid_lat1_we", 64'(we_o), 64'(0));
      tick();
      chk("rstmid_first_we", 64'(we_o), 64'(1));
      tick();
      chk("rstmid_second_we", 64'(we_o), 64'(1));
      tick();
      chk("rstmid_drained", 64'(exp_q.size()), 64'(0));

`ifdef FWB_FFLAGS_EN
      // Sticky flags accumulate; clear loses to a same-cycle commit.
      set_src(0, 1'b1, 5'd1, 32'h0000_0001);
      set_src(1, 1'b1, 5'd2, 32'h0000_0002);
      src_fflags_i[0 +: 5] = 5'b00001;
      src_fflags_i[5 +: 5] = 5'b10000;
      push(5'd1, 32'h0000_0001);
      push(5'd2, 32'h0000_0002);
      tick();
      src_valid_i = '0;
      repeat (3) tick();
      chk("fflags_accum", 64'(fflags_o), 64'(5'b10001));
      set_src(0, 1'b1, 5'd3, 32'h0000_0003);
      src_fflags_i[0 +: 5] = 5'b00100;
      push(5'd3, 32'h0000_0003);
      tick();
      src_valid_i = '0;
      tick();
      fflags_clr_i = 1'b1;
      tick();
      fflags_clr_i = 1'b0;
      chk("fflags_clr_commit", 64'(fflags_o), 64'(5'b00100));
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk("fflags_survive_flush", 64'(fflags_o), 64'(5'b00100));
`endif

      dv = 32'(exp_q.size());
      chk("final_queue_empty", 64'(dv), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
